// File: rtl/ariane_soc_pkg.sv
// rtl/ariane_soc_pkg.sv - shared serial-link framing constants and types
package ariane_soc;

  localparam int unsigned SerLinkFlitWidth  = 64;
  localparam int unsigned SerLinkNumLanes   = 4;
  localparam int unsigned SerLinkMaxCredits = 8;
  localparam logic [3:0]  SerLinkSof        = 4'hF;
  localparam logic [3:0]  SerLinkIdle       = 4'h0;

  typedef enum logic [1:0] {
    IDLE,
    SOF,
    DATA,
    PARITY
  } ser_link_tx_state_e;

  // Declared MSB-first so that bit l of the packed value is lane l.
  typedef struct packed {
    logic ddr3_o;
    logic ddr2_o;
    logic ddr1_o;
    logic ddr0_o;
  } ser_link_to_pad;

endpackage

// File: rtl/ser_link_credit_cnt.sv
// rtl/ser_link_credit_cnt.sv - saturating credit up/down counter with overflow pulse
module ser_link_credit_cnt #(
  parameter int unsigned MaxCount = 8,
  parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [CntW-1:0] o_count,
  output logic            o_err
);

  logic [CntW-1:0] r_count;
  logic            r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= CntW'(MaxCount);
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_inc && !i_dec) begin
        if (r_count == CntW'(MaxCount)) begin
          r_err <= 1'b1;
        end else begin
          r_count <= r_count + CntW'(1);
        end
      end else if (i_dec && !i_inc && (r_count != '0)) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_err   = r_err;

endmodule

// File: rtl/ser_link_tx.sv
// rtl/ser_link_tx.sv - serial link transmitter: SOF/data/parity framing with credit flow control
module ser_link_tx import ariane_soc::*; #(
  parameter int unsigned FlitWidth  = SerLinkFlitWidth,
  parameter int unsigned NumLanes   = SerLinkNumLanes,
  parameter int unsigned MaxCredits = SerLinkMaxCredits
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [FlitWidth-1:0]               data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic                               credit_return_i,
  output ser_link_to_pad                     pad_o,
  output logic                               busy_o,
  output logic [$clog2(MaxCredits+1)-1:0]    credits_o,
  output logic                               credit_err_o
);

  localparam int unsigned NumBeats = FlitWidth / NumLanes;
  localparam int unsigned BeatW    = $clog2(NumBeats);
  localparam int unsigned CredW    = $clog2(MaxCredits + 1);

  ser_link_tx_state_e   r_state, w_state_nxt;
  logic [BeatW-1:0]     r_beat, w_beat_nxt;
  logic [FlitWidth-1:0] r_shift, w_shift_nxt;
  logic [NumLanes-1:0]  r_parity, w_parity_nxt, w_parity_in;
  logic [NumLanes-1:0]  r_lanes, w_lanes_nxt;
  logic [CredW-1:0]     w_credits;
  logic                 w_accept;

  assign ready_o  = ((r_state == IDLE) || (r_state == PARITY)) && (w_credits != '0) && !rst_i;
  assign w_accept = valid_i && ready_o;

  always_comb begin
    w_parity_in = '0;
    for (int k = 0; k < NumBeats; k++) begin
      w_parity_in = w_parity_in ^ data_i[k*NumLanes +: NumLanes];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_beat   <= '0;
      r_shift  <= '0;
      r_parity <= '0;
      r_lanes  <= SerLinkIdle;
    end else begin
      r_state  <= w_state_nxt;
      r_beat   <= w_beat_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_lanes  <= w_lanes_nxt;
    end
  end

  // Lanes are computed for the state being entered so the pad beat lines up with r_state.
  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_lanes_nxt  = SerLinkIdle;
    if (w_accept) begin
      w_shift_nxt  = data_i;
      w_parity_nxt = w_parity_in;
    end
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SOF;
          w_lanes_nxt = SerLinkSof;
        end
      end
      SOF: begin
        w_state_nxt = DATA;
        w_beat_nxt  = '0;
        w_lanes_nxt = r_shift[NumLanes-1:0];
        w_shift_nxt = r_shift >> NumLanes;
      end
      DATA: begin
        if (r_beat == BeatW'(NumBeats - 1)) begin
          w_state_nxt = PARITY;
          w_lanes_nxt = r_parity;
        end else begin
          w_beat_nxt  = r_beat + BeatW'(1);
          w_lanes_nxt = r_shift[NumLanes-1:0];
          w_shift_nxt = r_shift >> NumLanes;
        end
      end
      PARITY: begin
        if (w_accept) begin
          w_state_nxt = SOF;
          w_lanes_nxt = SerLinkSof;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  ser_link_credit_cnt #(
    .MaxCount (MaxCredits),
    .CntW     (CredW)
  ) u_credit_cnt (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_inc   (credit_return_i),
    .i_dec   (w_accept),
    .o_count (w_credits),
    .o_err   (credit_err_o)
  );

  assign pad_o     = ser_link_to_pad'(r_lanes);
  assign busy_o    = (r_state != IDLE);
  assign credits_o = w_credits;

endmodule

// File: tb/tb_ser_link_tx.sv
// tb/tb_ser_link_tx.sv - self-checking bench for ser_link_tx
module tb_ser_link_tx;
  import ariane_soc::*;

  logic           clk;
  logic           rst_i;
  logic [63:0]    data_i;
  logic           valid_i;
  logic           ready_o;
  logic           credit_return_i;
  ser_link_to_pad pad_o;
  logic           busy_o;
  logic [3:0]     credits_o;
  logic           credit_err_o;
  logic [3:0]     pad_bits;

  assign pad_bits = pad_o;

  ser_link_tx dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .data_i          (data_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .credit_return_i (credit_return_i),
    .pad_o           (pad_o),
    .busy_o          (busy_o),
    .credits_o       (credits_o),
    .credit_err_o    (credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: a queue of lane beats still to be shown, plus a credit count.
  logic [3:0] m_q[$];
  logic [3:0] m_pad;
  logic       m_busy;
  int         m_cred;
  logic       m_err;

  logic [3:0] s_pad;
  logic       s_busy, s_err, s_ready;
  logic [3:0] s_cred;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  first_beat;
    logic [3:0]  last_beat;
    logic [3:0]  parity;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pad  = 4'h0;
    m_busy = 1'b0;
    m_cred = 8;
    m_err  = 1'b0;
  endtask

  task automatic push_frame(input logic [63:0] d);
    logic [3:0] p;
    p = 4'h0;
    m_q.push_back(4'hF);
    for (int k = 0; k < 16; k++) begin
      m_q.push_back(d[k*4 +: 4]);
      p = p ^ d[k*4 +: 4];
    end
    m_q.push_back(p);
  endtask

  // One clock: drive inputs, compare outputs with the model, advance model and DUT.
  task automatic cyc(input logic v, input logic [63:0] d, input logic ret, input logic rst);
    logic mr, acc;
    valid_i = v; data_i = d; credit_return_i = ret; rst_i = rst;
    #1;
    s_pad = pad_bits; s_busy = busy_o; s_cred = credits_o; s_err = credit_err_o; s_ready = ready_o;
    mr = (m_q.size() == 0) && (m_cred != 0) && !rst;
    chk("pad", pad_bits, m_pad);
    chk("busy", busy_o, m_busy);
    chk("credits", credits_o, m_cred[3:0]);
    chk("credit_err", credit_err_o, m_err);
    chk("ready", ready_o, mr);
    acc = v && mr;
    if (rst) begin
      model_reset();
    end else begin
      if (acc) push_frame(d);
      if (m_q.size() != 0) begin
        m_pad = m_q.pop_front(); m_busy = 1'b1;
      end else begin
        m_pad = 4'h0; m_busy = 1'b0;
      end
      m_err = 1'b0;
      if (acc && !ret) m_cred--;
      else if (ret && !acc) begin
        if (m_cred == 8) m_err = 1'b1;
        else m_cred++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t       vecs[5];
  logic [3:0] beats[20];
  int         hs;
  int         busy_low;
  int         err_pulses;

  initial begin
    vecs[0] = '{64'h0123_4567_89AB_CDEF, 4'hF, 4'h0, 4'h0};
    vecs[1] = '{64'h0000_0000_0000_0001, 4'h1, 4'h0, 4'h1};
    vecs[2] = '{64'h0000_0000_0000_00F0, 4'h0, 4'h0, 4'hF};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'hF, 4'h0};
    vecs[4] = '{64'h8000_0000_0000_0003, 4'h3, 4'h8, 4'hB};

    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; credit_return_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    cyc(0, 64'h0, 0, 1);
    chk("reset_ready", s_ready, 1'b0);
    cyc(0, 64'h0, 0, 0);
    chk("reset_pad", s_pad, 4'h0);
    chk("reset_credits", s_cred, 4'd8);
    chk("reset_busy", s_busy, 1'b0);
    chk("reset_err", s_err, 1'b0);

    // Table-driven single flits from idle
    for (int i = 0; i < 5; i++) begin
      cyc(1, vecs[i].data, 0, 0);
      beats[0] = s_pad;
      for (int j = 1; j < 20; j++) begin
        cyc(0, 64'h0, (j == 5), 0);
        beats[j] = s_pad;
        if (i == 0 && j == 1) chk("credits_after_accept", s_cred, 4'd7);
      end
      chk("pre_sof", beats[0], 4'h0);
      chk("sof", beats[1], 4'hF);
      chk("first_beat", beats[2], vecs[i].first_beat);
      chk("last_beat", beats[17], vecs[i].last_beat);
      chk("parity_beat", beats[18], vecs[i].parity);
      chk("post_frame", beats[19], 4'h0);
    end

    // Back-to-back with valid held high
    hs = 0; busy_low = 0;
    cyc(1, 64'hDEAD_BEEF_0000_1111, 0, 0);
    if (s_ready) hs++;
    for (int j = 1; j <= 18; j++) begin
      cyc(1, 64'h1234_5678_9ABC_DEF0, 0, 0);
      if (s_ready) hs++;
      if (!s_busy) busy_low++;
    end
    cyc(0, 64'h0, 0, 0);
    chk("b2b_second_sof", s_pad, 4'hF);
    if (!s_busy) busy_low++;
    for (int j = 20; j <= 36; j++) begin
      cyc(0, 64'h0, (j == 25 || j == 26), 0);
      if (!s_busy) busy_low++;
    end
    chk("b2b_handshakes", hs, 2);
    chk("b2b_busy_low_cycles", busy_low, 0);
    cyc(0, 64'h0, 0, 0);
    chk("b2b_idle_after", s_busy, 1'b0);

    // Credit boundary at full credits
    cyc(0, 64'h0, 0, 1);
    cyc(1, 64'h5555_AAAA_5555_AAAA, 1, 0);
    cyc(0, 64'h0, 1, 0);
    chk("bnd_same_cycle_credits", s_cred, 4'd8);
    chk("bnd_same_cycle_err", s_err, 1'b0);
    err_pulses = 0;
    for (int j = 0; j < 20; j++) begin
      cyc(0, 64'h0, 0, 0);
      if (s_err) err_pulses++;
      if (j == 0) chk("bnd_overflow_credits", s_cred, 4'd8);
    end
    chk("bnd_overflow_pulses", err_pulses, 1);

    // Credit exhaustion: 9 flits, no returns
    hs = 0;
    for (int j = 0; j < 170; j++) begin
      cyc(1, {$urandom, $urandom}, 0, 0);
      if (s_ready) hs++;
    end
    chk("exh_accepted", hs, 8);
    chk("exh_ready_low", s_ready, 1'b0);
    chk("exh_credits_zero", s_cred, 4'd0);
    cyc(1, 64'hCAFE_F00D_0000_0009, 1, 0);
    chk("exh_ready_before_return", s_ready, 1'b0);
    cyc(1, 64'hCAFE_F00D_0000_0009, 0, 0);
    chk("exh_ready_after_return", s_ready, 1'b1);
    for (int j = 0; j < 20; j++) cyc(0, 64'h0, (j < 8), 0);
    chk("exh_credits_restored", s_cred, 4'd8);

    // Reset mid-frame at data beat 5
    cyc(1, 64'hFEDC_BA98_7654_3210, 0, 0);
    for (int j = 1; j <= 6; j++) cyc(0, 64'h0, 0, 0);
    cyc(0, 64'h0, 0, 1);
    chk("rst_mid_beat5", s_pad, 4'h5);
    cyc(0, 64'h0, 1, 1);
    chk("rst_mid_lanes", s_pad, 4'h0);
    chk("rst_mid_credits", s_cred, 4'd8);
    chk("rst_mid_ready", s_ready, 1'b0);
    cyc(0, 64'h0, 0, 0);
    chk("rst_after_ready", s_ready, 1'b1);
    chk("rst_after_err", s_err, 1'b0);
    cyc(1, 64'h0000_0000_0000_0042, 0, 0);
    cyc(0, 64'h0, 0, 0);
    chk("rst_new_sof", s_pad, 4'hF);
    cyc(0, 64'h0, 0, 0);
    chk("rst_new_beat0", s_pad, 4'h2);
    for (int j = 0; j < 18; j++) cyc(0, 64'h0, (j == 3), 0);

    // Randomized traffic against the model
    for (int j = 0; j < 600; j++) begin
      cyc(($urandom_range(0, 3) != 0), {$urandom, $urandom},
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 249) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ser_link_tx.md
# ser_link_tx

Transmit end of the SoC serial link. It accepts 64-bit flits over a valid/ready handshake and frames each one as a start beat, data beats and a parity beat. The frame is driven onto the four link lanes of the `ser_link_to_pad` struct, one bit per lane per clock. It sits between the SoC-side serial-link adapter and the pad ring, and applies credit-based flow control using credit returns from the far-end receiver.

## Interface
Parameters:
- `FlitWidth`, default 64: flit width; must be a multiple of `NumLanes`.
- `NumLanes`, default 4: link lanes; fixed by the width of `ser_link_to_pad`.
- `MaxCredits`, default 8: receiver buffer depth in flits; also the credit reset value.

Ports:
- `clk_i`, in, 1: the only clock. The block runs from `clk_i` alone.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `data_i`, in, `FlitWidth`: flit payload.
- `valid_i`, in, 1: flit valid.
- `ready_o`, out, 1: flit accepted when `valid_i && ready_o`.
- `credit_return_i`, in, 1: one-cycle pulse; receiver has freed one flit buffer.
- `pad_o`, out, `ariane_soc::ser_link_to_pad`: lanes; `ddr0_o` is lane 0 … `ddr3_o` is lane 3.
- `busy_o`, out, 1: a frame is in flight.
- `credits_o`, out, `$clog2(MaxCredits+1)`: current credit count.
- `credit_err_o`, out, 1: one-cycle pulse on credit overflow.

## Operation
- `NumBeats` = `FlitWidth`/`NumLanes` (16 by default). The beat counter is `$clog2(NumBeats)` bits wide.
- FSM states are IDLE, SOF, DATA and PARITY.
  - IDLE: lanes = 4'h0. On accept, go to SOF.
  - SOF: lanes = 4'hF. Go to DATA with beat counter = 0.
  - DATA: beat k drives lane l = `data[k*NumLanes+l]`, i.e. LSB nibble first. After beat `NumBeats-1`, go to PARITY.
  - PARITY: lane l = XOR over k of `data[k*NumLanes+l]` (per-lane even parity). On accept in this state, go to SOF; otherwise go to IDLE.
- `ready_o` = (state ∈ {IDLE, PARITY}) && credits != 0 && !rst_i. The output is combinational from registered state.
- On accept:
  - `data_i` is captured into the shift register.
  - Parity for all lanes is computed from `data_i` and registered.
  - Credits decrement by 1.
- Credit return: credits increment by 1.
  - Accept and return in the same cycle: net unchanged.
  - Return at `MaxCredits` with no accept: credits saturate (stay at `MaxCredits`) and `credit_err_o` pulses for one cycle.
- The payload is not modified; no X-propagation to the lanes in IDLE.
- `busy_o` = state != IDLE.

## Timing
- Reset values:
  - state = IDLE
  - `pad_o` = all 0
  - `ready_o` = 0 while `rst_i` is high
  - `busy_o` = 0
  - `credits_o` = `MaxCredits`
  - `credit_err_o` = 0
- Lanes are registered. Accept at cycle t gives:
  - SOF on `pad_o` at t+1
  - data beats at t+2 … t+1+`NumBeats` (t+2…t+17 by default)
  - PARITY at t+`NumBeats`+2 (t+18)
- Back-to-back: an accept during the PARITY beat gives SOF on the next cycle. Frame period is 18 cycles with no idle gap.
- Reset mid-frame aborts the frame:
  - lanes read 0 on the cycle after `rst_i` is sampled high;
  - credits return to `MaxCredits`;
  - the far end resynchronises on the next SOF.
- Credit changes are visible on `credits_o` the cycle after the event. `ready_o` reflects the updated count in that same cycle.
- `credit_return_i` during reset is ignored.

## Structure
- `ariane_soc` gains:
  - `SerLinkFlitWidth` = 64
  - `SerLinkNumLanes` = 4
  - `SerLinkMaxCredits` = 8
  - `SerLinkSof` = 4'hF
  - `SerLinkIdle` = 4'h0
  - `ser_link_tx_state_e` enum {IDLE, SOF, DATA, PARITY}
- The receiver reuses these so that framing stays single-sourced.
- One sub-module: `ser_link_credit_cnt`. It is a saturating up/down counter with an overflow pulse, and will be shared with the receiver's credit-return generator. The FSM and the shift register stay in `ser_link_tx`.

## Test plan
- Single flit 64'h0123_4567_89AB_CDEF, credits = 8, accepted at t. Required lanes:
  - 4'h0 before t+1
  - SOF 4'hF at t+1
  - beats F,E,D,C,B,A,9,8,7,6,5,4,3,2,1,0 at t+2…t+17
  - parity 4'h0 at t+18
  - 4'h0 at t+19
  - `credits_o` = 7
- Parity check: flit 64'h1 gives parity beat 4'h1. Flit 64'h0000_0000_0000_00F0 gives parity beat 4'hF.
- Back-to-back: `valid_i` held high with two flits. Second SOF appears exactly at t+19 with no idle beat, and `busy_o` stays high throughout.
- Credit exhaustion: send 9 flits with no returns.
  - Exactly 8 are accepted; `ready_o` stays low after the 8th.
  - A single `credit_return_i` pulse makes `ready_o` rise the next cycle, and the 9th flit is sent.
- Credit boundary cases:
  - At credits = 8, return and accept in the same cycle leave credits at 8 with no error.
  - A return at 8 with no accept keeps credits at 8 and pulses `credit_err_o` once.
- Reset mid-frame: assert `rst_i` at DATA beat 5 for 2 cycles.
  - Lanes go to 0 on the next cycle; `credits_o` = 8; `ready_o` = 0 during reset and 1 after.
  - A new flit then frames normally.
